// File: rtl/fst1_pkg.sv
// Shared constants, per-group record type and width helpers for the
// pipelined first-one detector.
package fst1_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    // Wide enough for any group up to 256 bits; narrower groups zero-extend.
    localparam int LIDX_W = 8;

    typedef struct packed {
        logic              found;
        logic [LIDX_W-1:0] local_idx;
    } grp_rec_t;

    function automatic int pos_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int idx_w(input int group_w);
        return (group_w > 1) ? $clog2(group_w) : 1;
    endfunction

endpackage

// File: rtl/fst1_grp_enc.sv
// Combinational GROUP_W-bit priority encoder; mode picks highest (MSB-first)
// or lowest (LSB-first) set bit.
module fst1_grp_enc
    import fst1_pkg::*;
#(
    parameter int GROUP_W = 8
) (
    input  logic [GROUP_W-1:0]        grp,
    input  logic                      mode,
    output logic                      found,
    output logic [idx_w(GROUP_W)-1:0] idx
);

    localparam int IDX_W = idx_w(GROUP_W);

    logic hit;

    // Ascending scan: MSB-first lets the last hit win, LSB-first keeps the first.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (grp[i] && (mode == MODE_MSB || !hit)) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
        found = hit;
    end

endmodule

// File: rtl/fst1_detect_pipe.sv
// Three-stage first-one detector with valid/ready back-pressure, all-zero flag
// and a saturating count of delivered all-zero words.
module fst1_detect_pipe
    import fst1_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int GROUP_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pos_w(DATA_W)-1:0] out_pos,
    output logic                     out_zero,
    output logic [CNT_W-1:0]         zero_cnt,
    input  logic                     cnt_clr
);

    localparam int STAGES = 3;
    localparam int NG     = DATA_W / GROUP_W;
    localparam int IDX_W  = idx_w(GROUP_W);
    localparam int POS_W  = pos_w(DATA_W);

    logic [STAGES:1] vld_pipe;
    logic            ld1, ld2, ld3;

    logic [DATA_W-1:0] s1_data;
    logic              s1_mode;

    logic [NG-1:0]            enc_found;
    logic [NG-1:0][IDX_W-1:0] enc_idx;
    grp_rec_t [NG-1:0]        enc_rec;

    grp_rec_t [NG-1:0] s2_rec;
    logic              s2_mode;

    logic [POS_W-1:0] sel_pos;
    logic             sel_zero;
    logic             out_xfer;

    // Ready ripples back from the output so a full pipe still streams.
    assign ld3       = ~vld_pipe[3] | out_ready;
    assign ld2       = ~vld_pipe[2] | ld3;
    assign ld1       = ~vld_pipe[1] | ld2;
    assign in_ready  = ld1;
    assign out_valid = vld_pipe[3];
    assign out_xfer  = vld_pipe[3] & out_ready;

    fst1_grp_enc #(.GROUP_W(GROUP_W)) u_enc [NG-1:0] (
        .grp   (s1_data),
        .mode  (s1_mode),
        .found (enc_found),
        .idx   (enc_idx)
    );

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            enc_rec[g].found     = enc_found[g];
            enc_rec[g].local_idx = LIDX_W'(enc_idx[g]);
        end
    end

    // Group select uses the same last-wins / first-wins trick as the encoder.
    always_comb begin
        sel_zero = 1'b1;
        sel_pos  = POS_W'(DATA_W);
        for (int g = 0; g < NG; g++) begin
            if (s2_rec[g].found && (s2_mode == MODE_MSB || sel_zero)) begin
                sel_pos  = POS_W'(g * GROUP_W) + POS_W'(s2_rec[g].local_idx);
                sel_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_mode  <= MODE_MSB;
            s2_rec   <= '0;
            s2_mode  <= MODE_MSB;
            out_pos  <= '0;
            out_zero <= 1'b0;
        end else begin
            if (ld1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_mode <= in_mode;
                end
            end
            if (ld2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_rec  <= enc_rec;
                    s2_mode <= s1_mode;
                end
            end
            if (ld3) begin
                vld_pipe[3] <= vld_pipe[2];
                if (vld_pipe[2]) begin
                    out_pos  <= sel_pos;
                    out_zero <= sel_zero;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            zero_cnt <= '0;
        else if (cnt_clr)
            zero_cnt <= '0;
        else if (out_xfer && out_zero && zero_cnt != {CNT_W{1'b1}})
            zero_cnt <= zero_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fst1_detect_pipe.sv
// Bench for fst1_detect_pipe: vector table, hand sequences for latency/stall/
// counter/reset, and randomized traffic against a bit-scan reference model.
module tb_fst1_detect_pipe;
    import fst1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero, cnt_clr;
    logic [31:0] in_data;
    logic [5:0]  out_pos;
    logic [15:0] zero_cnt;

    logic        in_valid2, in_ready2, in_mode2, out_valid2, out_ready2, out_zero2, cnt_clr2;
    logic [63:0] in_data2;
    logic [6:0]  out_pos2;
    logic [15:0] zero_cnt2;

    fst1_detect_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_pos(out_pos), .out_zero(out_zero),
        .zero_cnt(zero_cnt), .cnt_clr(cnt_clr)
    );

    fst1_detect_pipe #(.DATA_W(64), .GROUP_W(16), .CNT_W(16)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_mode(in_mode2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_pos(out_pos2), .out_zero(out_zero2),
        .zero_cnt(zero_cnt2), .cnt_clr(cnt_clr2)
    );

    typedef struct packed {
        logic       zero;
        logic [5:0] pos;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [5:0]  pos;
        logic        zero;
    } vec_t;

    int          passed = 0;
    int          total  = 0;
    exp_t        q[$];
    exp_t        pend;
    logic [15:0] zc_m;
    bit          last_in_x;
    vec_t        tbl[16];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: scan every bit, remember lowest and highest set positions.
    function automatic exp_t model(input logic [31:0] d, input logic m);
        int   lo = -1;
        int   hi = -1;
        exp_t r;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (hi < 0) begin
            r.zero = 1'b1;
            r.pos  = 6'd32;
        end else begin
            r.zero = 1'b0;
            r.pos  = 6'((m == MODE_LSB) ? lo : hi);
        end
        return r;
    endfunction

    task automatic offer(input logic [31:0] d, input logic m, input exp_t e);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        pend     = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample handshakes at the falling edge, update scoreboard after the rising edge.
    task automatic tick();
        bit         in_x, out_x, clr;
        logic [5:0] op;
        logic       oz;
        exp_t       e;
        @(negedge clk);
        in_x  = in_valid & in_ready;
        out_x = out_valid & out_ready;
        op    = out_pos;
        oz    = out_zero;
        clr   = cnt_clr;
        @(posedge clk);
        #1;
        if (in_x) q.push_back(pend);
        if (out_x) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL out_spurious: got pos %0d zero %0d, expected no output", op, oz);
            end else begin
                e = q.pop_front();
                chk("out_pos", op, e.pos);
                chk("out_zero", oz, e.zero);
                if (!clr && e.zero && zc_m != 16'hFFFF) zc_m++;
            end
        end
        if (clr) zc_m = '0;
        chk("zero_cnt", zero_cnt, zc_m);
        last_in_x = in_x;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int n = 0; n < 30 && q.size() != 0; n++) tick();
        chk("drain_empty", q.size(), 0);
        tick();
        tick();
    endtask

    task automatic run64(input logic [63:0] d, input logic m, input int ep, input logic ez);
        int n = 0;
        in_valid2 = 1'b1;
        in_data2  = d;
        in_mode2  = m;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        while (!out_valid2 && n < 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w64_latency", n, 2);
        chk("w64_pos", out_pos2, ep);
        chk("w64_zero", out_zero2, ez);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] sw[5];
        logic [31:0] d;
        logic        m;
        int          acc;

        tbl[0]  = '{32'h18800000, MODE_MSB, 6'd28, 1'b0};
        tbl[1]  = '{32'h00FF0000, MODE_MSB, 6'd23, 1'b0};
        tbl[2]  = '{32'h0000000A, MODE_MSB, 6'd3,  1'b0};
        tbl[3]  = '{32'h18800000, MODE_LSB, 6'd23, 1'b0};
        tbl[4]  = '{32'h00FF0000, MODE_MSB, 6'd23, 1'b0};
        tbl[5]  = '{32'h0000000A, MODE_LSB, 6'd1,  1'b0};
        tbl[6]  = '{32'h80000000, MODE_MSB, 6'd31, 1'b0};
        tbl[7]  = '{32'h80000000, MODE_LSB, 6'd31, 1'b0};
        tbl[8]  = '{32'h00000001, MODE_MSB, 6'd0,  1'b0};
        tbl[9]  = '{32'h00000001, MODE_LSB, 6'd0,  1'b0};
        tbl[10] = '{32'h00000000, MODE_MSB, 6'd32, 1'b1};
        tbl[11] = '{32'h00000000, MODE_LSB, 6'd32, 1'b1};
        tbl[12] = '{32'hFFFFFFFF, MODE_MSB, 6'd31, 1'b0};
        tbl[13] = '{32'hFFFFFFFF, MODE_LSB, 6'd0,  1'b0};
        tbl[14] = '{32'h00000100, MODE_MSB, 6'd8,  1'b0};
        tbl[15] = '{32'h00800080, MODE_LSB, 6'd7,  1'b0};

        rstn = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mode = MODE_MSB; out_ready = 1'b1; cnt_clr = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; in_mode2 = MODE_MSB; out_ready2 = 1'b1; cnt_clr2 = 1'b0;
        zc_m = '0;
        pend = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_pos", out_pos, 0);
        chk("reset_out_zero", out_zero, 0);
        chk("reset_zero_cnt", zero_cnt, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);

        // Capture at edge k, result visible from edge k+2.
        offer(32'h18800000, MODE_MSB, '{zero: 1'b0, pos: 6'd28});
        tick();
        idle();
        chk("lat_k_valid", out_valid, 0);
        tick();
        chk("lat_k1_valid", out_valid, 0);
        tick();
        chk("lat_k2_valid", out_valid, 1);
        chk("lat_k2_pos", out_pos, 28);
        drain();

        for (int i = 0; i < 16; i++) begin
            offer(tbl[i].data, tbl[i].mode, '{zero: tbl[i].zero, pos: tbl[i].pos});
            chk("tbl_in_ready", in_ready, 1);
            tick();
            if (i >= 2) chk("tbl_back_to_back", out_valid, 1);
        end
        drain();

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("zc_cleared", zero_cnt, 0);
        offer(32'h0, MODE_MSB, model(32'h0, MODE_MSB));
        tick();
        offer(32'h0, MODE_LSB, model(32'h0, MODE_LSB));
        tick();
        drain();
        chk("zc_two", zero_cnt, 2);
        offer(32'h0, MODE_MSB, model(32'h0, MODE_MSB));
        tick();
        idle();
        tick();
        tick();
        chk("zc_third_valid", out_valid, 1);
        chk("zc_pre_clr", zero_cnt, 2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("zc_clr_priority", zero_cnt, 0);
        drain();

        sw[0] = 32'h00000100; sw[1] = 32'h40000000; sw[2] = 32'h00000000;
        sw[3] = 32'h0000F000; sw[4] = 32'h00010001;
        out_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 10 && acc < 3; n++) begin
            m = 1'(acc & 1);
            offer(sw[acc], m, model(sw[acc], m));
            tick();
            if (last_in_x) acc++;
        end
        chk("stall_accepted", acc, 3);
        m = 1'(acc & 1);
        offer(sw[acc], m, model(sw[acc], m));
        for (int n = 0; n < 4; n++) begin
            chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_no_accept", last_in_x, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_pos", out_pos, q[0].pos);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        for (int n = 0; n < 10 && acc < 5; n++) begin
            m = 1'(acc & 1);
            offer(sw[acc], m, model(sw[acc], m));
            tick();
            if (last_in_x) acc++;
        end
        chk("stall_all_in", acc, 5);
        drain();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: d = 32'h0;
                    1: d = 32'h1 << $urandom_range(0, 31);
                    2: d = $urandom;
                    default: d = $urandom & $urandom & $urandom;
                endcase
                m = 1'($urandom_range(0, 1));
                offer(d, m, model(d, m));
            end else begin
                idle();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        cnt_clr = 1'b0;
        drain();

        run64(64'h1 << 47, MODE_MSB, 47, 1'b0);
        run64(64'h1 << 47, MODE_LSB, 47, 1'b0);
        run64(64'h8000_0000_0001_0000, MODE_LSB, 16, 1'b0);
        run64(64'h0, MODE_MSB, 64, 1'b1);

        offer(32'h0, MODE_LSB, model(32'h0, MODE_LSB));
        tick();
        idle();
        drain();
        out_ready = 1'b0;
        offer(32'h00001000, MODE_MSB, model(32'h00001000, MODE_MSB));
        tick();
        offer(32'h00000030, MODE_LSB, model(32'h00000030, MODE_LSB));
        tick();
        idle();
        tick();
        chk("rst_pre_valid", out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_zero_cnt", zero_cnt, 0);
        chk("rst_out_zero", out_zero, 0);
        q.delete();
        zc_m = '0;
        out_ready = 1'b1;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("post_rst_idle", out_valid, 0);
        end
        offer(32'h00000400, MODE_LSB, model(32'h00000400, MODE_LSB));
        tick();
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
